// File: rtl/prbs_chk_if.sv
// Receive-side word bus between the GT datapath and the PRBS checker.
// The master drives received words; the slave returns lock status and counters.
interface prbs_chk_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] data_in;
    logic            data_valid_in;
    logic            clear_counts_in;
    logic            locked_out;
    logic            error_out;
    logic [31:0]     bit_err_count_out;
    logic [47:0]     word_count_out;

    modport master (
        output data_in,
        output data_valid_in,
        output clear_counts_in,
        input  locked_out,
        input  error_out,
        input  bit_err_count_out,
        input  word_count_out
    );

    modport slave (
        input  data_in,
        input  data_valid_in,
        input  clear_counts_in,
        output locked_out,
        output error_out,
        output bit_err_count_out,
        output word_count_out
    );
endinterface

// File: rtl/prbs_chk.sv
// Self-synchronising PRBS checker: searches for lock with a feed-forward
// predictor, then compares against a free-running local LFSR and counts errors.
module prbs_chk #(
    parameter int                SIZE         = 32,
    parameter int                LENGTH       = 7,
    parameter logic [LENGTH-1:0] PRIMPOLY     = 7'b1100000,
    parameter int                LOCK_WORDS   = 16,
    parameter int                UNLOCK_WORDS = 4
) (
    input logic       gtwiz_userclk_rx_usrclk2_in,
    input logic       gtwiz_reset_all_in,
    prbs_chk_if.slave bus
);
    localparam int GW = $clog2(LOCK_WORDS + 1);
    localparam int BW = $clog2(UNLOCK_WORDS + 1);
    localparam int PW = $clog2(SIZE + 1);
    localparam int XW = SIZE + LENGTH;

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_e;

    state_e            state_q, state_d;
    logic [LENGTH-1:0] hist_q, hist_d;
    logic [LENGTH-1:0] lfsr_q, lfsr_d;
    logic              hist_ok_q, hist_ok_d;
    logic [GW-1:0]     good_q, good_d;
    logic [BW-1:0]     bad_q, bad_d;
    logic              error_q, error_d;
    logic [31:0]       bec_q, bec_d;
    logic [47:0]       wc_q, wc_d;

    logic [XW-1:0]     rx_ext;
    logic [XW-1:0]     ex_ext;
    logic [SIZE-1:0]   pred;
    logic [SIZE-1:0]   expw;
    logic [SIZE-1:0]   err_mask;
    logic [PW-1:0]     pc;
    logic [32:0]       bsum;
    logic [31:0]       bec_sat;
    logic [47:0]       wc_sat;
    logic              good_word;
    logic              bad_word;

    // Each bit predicted from the received bits before it (history + word).
    always_comb begin
        rx_ext = {bus.data_in, hist_q};
        pred   = '0;
        for (int j = 0; j < SIZE; j++) begin
            for (int i = 0; i < LENGTH; i++) begin
                if (PRIMPOLY[i]) begin
                    pred[j] = pred[j] ^ rx_ext[LENGTH+j-i-1];
                end
            end
        end
    end

    // Local sequence extends from the LFSR, never from received data.
    always_comb begin
        ex_ext = {{SIZE{1'b0}}, lfsr_q};
        for (int j = 0; j < SIZE; j++) begin
            for (int i = 0; i < LENGTH; i++) begin
                if (PRIMPOLY[i]) begin
                    ex_ext[LENGTH+j] = ex_ext[LENGTH+j] ^ ex_ext[LENGTH+j-i-1];
                end
            end
        end
        expw = ex_ext[XW-1:LENGTH];
    end

    always_comb begin
        err_mask = bus.data_in ^ expw;
        pc       = '0;
        for (int j = 0; j < SIZE; j++) begin
            pc = pc + PW'(err_mask[j]);
        end
    end

    always_comb begin
        bsum    = {1'b0, bec_q} + {{(33 - PW){1'b0}}, pc};
        bec_sat = bsum[32] ? '1 : bsum[31:0];
        wc_sat  = (&wc_q) ? wc_q : wc_q + 48'd1;
    end

    assign good_word = hist_ok_q && (pred == bus.data_in);
    assign bad_word  = |err_mask;

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        lfsr_d    = lfsr_q;
        hist_ok_d = hist_ok_q;
        good_d    = good_q;
        bad_d     = bad_q;
        error_d   = 1'b0;
        bec_d     = bec_q;
        wc_d      = wc_q;
        if (bus.data_valid_in) begin
            hist_d    = bus.data_in[SIZE-1 -: LENGTH];
            hist_ok_d = 1'b1;
            unique case (state_q)
                SEARCH: begin
                    if (!good_word) begin
                        good_d = '0;
                    end else if (good_q == GW'(LOCK_WORDS - 1)) begin
                        state_d = LOCKED;
                        good_d  = '0;
                        bad_d   = '0;
                        lfsr_d  = bus.data_in[SIZE-1 -: LENGTH];
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                end
                LOCKED: begin
                    lfsr_d  = ex_ext[XW-1 -: LENGTH];
                    bec_d   = bec_sat;
                    wc_d    = wc_sat;
                    error_d = bad_word;
                    if (!bad_word) begin
                        bad_d = '0;
                    end else if (bad_q == BW'(UNLOCK_WORDS - 1)) begin
                        state_d   = SEARCH;
                        bad_d     = '0;
                        good_d    = '0;
                        hist_ok_d = 1'b0;
                    end else begin
                        bad_d = bad_q + BW'(1);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        if (bus.clear_counts_in) begin
            bec_d = '0;
            wc_d  = '0;
        end
    end

    always_ff @(posedge gtwiz_userclk_rx_usrclk2_in) begin
        if (gtwiz_reset_all_in) begin
            state_q   <= SEARCH;
            hist_q    <= '0;
            lfsr_q    <= '0;
            hist_ok_q <= 1'b0;
            good_q    <= '0;
            bad_q     <= '0;
            error_q   <= 1'b0;
            bec_q     <= '0;
            wc_q      <= '0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            lfsr_q    <= lfsr_d;
            hist_ok_q <= hist_ok_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            error_q   <= error_d;
            bec_q     <= bec_d;
            wc_q      <= wc_d;
        end
    end

    assign bus.locked_out        = (state_q == LOCKED);
    assign bus.error_out         = error_q;
    assign bus.bit_err_count_out = bec_q;
    assign bus.word_count_out    = wc_q;
endmodule

// File: doc/prbs_chk.md
# prbs_chk

PRBS checker for the GT receive datapath, the counterpart of the transmit-side PRBS generator. It runs on the RX user clock and locks onto the incoming pseudo-random word stream without an external seed. Once locked, it compares each received word bit-by-bit against a locally generated sequence and reports per-word errors, a bit-error count and a received-word count for link BER measurement.

## Interface
- size, 32, data word width in bits; must satisfy length <= size
- length, 7, LFSR length in bits
- primpoly, 7'b1100000, feedback taps indexed [0:length-1]; bit i set means a tap at delay i+1 (default is x^7+x^6+1, PRBS7)
- lock_words, 16, consecutive error-free valid words needed to enter LOCKED
- unlock_words, 4, consecutive errored valid words in LOCKED that force a return to SEARCH

Ports:
- gtwiz_userclk_rx_usrclk2_in  in  1  clock; all logic on the rising edge
- gtwiz_reset_all_in  in  1  reset, synchronous, active-high
- data_in  in  size  received word; data_in[0] is the earliest bit in sequence order
- data_valid_in  in  1  data_in is valid this cycle
- clear_counts_in  in  1  synchronous clear of both counters
- locked_out  out  1  checker is in LOCKED
- error_out  out  1  previous valid word had one or more bit errors while LOCKED
- bit_err_count_out  out  32  saturating bit-error count while LOCKED
- word_count_out  out  48  saturating count of valid words while LOCKED

## Operation
- Sequence rule: s[n] = XOR of s[n-i-1] over every i with primpoly[i]=1. Bits within a word run from index 0 upward, and words follow each other in order.
- hist: a length-bit register holding the last length received bits. It updates on every valid word. hist_ok is set by the first valid word after reset or after entering SEARCH.
- SEARCH (reset state):
  - Predict each bit of data_in from hist plus the earlier bits of the same word, using the self-synchronizing feed-forward method.
  - A word is good if hist_ok=1 and the prediction matches the word exactly.
  - good_cnt increments on a good word and clears on any other valid word.
  - When good_cnt reaches lock_words, go to LOCKED. At the same time, load the local LFSR with the last length bits of that word.
- LOCKED:
  - The expected word is generated from the local LFSR, which advances size bits per valid word.
  - err_mask = data_in XOR expected.
  - bit_err_count_out += popcount(err_mask). word_count_out += 1.
  - bad_cnt increments on a word with a nonzero mask and clears on an error-free word.
  - When bad_cnt reaches unlock_words, go to SEARCH. On that transition, clear good_cnt and hist_ok. The counters hold their values.
- data_valid_in=0: no state, LFSR, history or counter change.
- Counters saturate at all-ones; they never wrap.
- clear_counts_in zeroes both counters. If it coincides with an increment, the clear wins and the result is 0. It does not affect lock state.
- Reset mid-operation returns every register to its reset value on the next edge, regardless of the other inputs.

## Timing
- Reset values: locked_out=0, error_out=0, bit_err_count_out=0, word_count_out=0, state=SEARCH, good_cnt=bad_cnt=0, hist_ok=0.
- All outputs are registered. A valid word at edge N shows its effect on error_out and the counters after edge N (1-cycle latency).
- error_out is a one-cycle pulse and is 0 after any invalid cycle.
- locked_out rises on the edge that accepts the lock_words-th good word. The first compared word in LOCKED is the next valid word.
- locked_out falls on the edge that accepts the unlock_words-th consecutive bad word. That word still counts in both counters.
- No backpressure; one word per cycle at full rate.

## Test plan
- Reset, then an error-free PRBS7 stream with valid every cycle: locked_out rises on the edge accepting word 17 (one history-priming word plus 16 good words); after 1000 further words, word_count_out=1000, bit_err_count_out=0, error_out never 1.
- Locked, flip bits 3 and 20 of one word: error_out=1 for exactly one cycle, bit_err_count_out increments by exactly 2 (no error multiplication), lock is held.
- Locked, then 4 consecutive words of all-zero data: bit_err_count_out increases by the popcount of the 4 expected words, locked_out falls after the 4th; a clean stream then relocks after 16 good words.
- Valid toggled 1/0 randomly on a clean stream: locks after 17 valid words; word_count_out equals the number of valid words after lock.
- bit_err_count_out forced near saturation via long all-ones injection (or a reduced-width build): the counter holds at all-ones; clear_counts_in asserted during an errored word gives 0 next cycle.
- gtwiz_reset_all_in pulsed for 1 cycle while locked: the next cycle shows all outputs at reset values and state SEARCH.
